data_unpacking: RTL and testbench
=================================

// Module: data_unpacking
// PURPOSE
//  Reader side of the pixel frame FIFO: pops 32-bit words, finds the frame header and
//  checks the 16'h55AA ID word, then emits pixels as a 16-bit stream (upper half first).
//  Checks word count, frame number and tail, and reports per-frame status.
//  Feeds readout/monitoring logic in the clk_200m domain.
// PARAMETERS
//  PIXELS_PER_FRAME  5184  pixels per frame; must be even; data words = PIXELS_PER_FRAME/2
// PORTS
//  clk_200m      in   1   clock
//  reset         in   1   synchronous reset, active high
//  header        in   32  expected header word
//  tail          in   32  expected tail word
//  fifo_empty    in   1   FIFO empty flag
//  fifo_dout     in   32  FIFO read data, valid 1 cycle after fifo_rden
//  fifo_rden     out  1   FIFO read enable
//  pixel_valid   out  1   pixel_data/pixel_index valid this cycle
//  pixel_data    out  16  pixel value
//  pixel_index   out  16  0..PIXELS_PER_FRAME-1 within the current frame
//  chip_number   out  4   ID word [3:0], latched per frame
//  frame_num     out  32  frame-number word of the last completed frame
//  frame_done    out  1   1-cycle pulse after the tail word is consumed
//  frame_ok      out  1   valid with frame_done; 1 = tail matched (and seq ok if enabled)
//  id_err        out  1   1-cycle pulse: word after header was not 16'h55AA
//  seq_err       out  1   1-cycle pulse with frame_done: frame number not previous+1
//  up_status     out  6   one-hot current state
// BEHAVIOUR
//  Reset: all outputs 0; state HUNT; counters 0; no read outstanding. A reset asserted
//   mid-frame discards the frame: no frame_done and the next word after reset is hunted.
//  Reads: fifo_rden=1 iff state consumes words, !fifo_empty, no read outstanding, and
//   no data word holds an unemitted upper half. Word arrives the cycle after fifo_rden.
//  States (one-hot): HUNT, ID, DATA, FNUM, TAIL, DONE.
//   HUNT: drop words until word==header -> ID.
//   ID: word[31:16]==16'h55AA -> latch chip_number=word[3:0], pixel_index=0, -> DATA;
//       else pulse id_err -> HUNT. If the word equals header, stay in ID
//       (re-synchronise on the new header).
//   DATA: for each word: cycle after arrival pixel_valid=1 with word[31:16]; next cycle
//       word[15:0]; pixel_index increments per pixel. Sustained 1 word per 2 cycles.
//       After the lower half of word PIXELS_PER_FRAME/2 -> FNUM. No header check in DATA.
//   FNUM: next word latched internally as the candidate frame number -> TAIL.
//   TAIL: next word compared with tail -> DONE.
//   DONE: one cycle: frame_done=1; frame_num updated; frame_ok=(tail match)&!seq_err;
//       -> HUNT.
//  Width: pixel_index 16 bit; the last pixel carries PIXELS_PER_FRAME-1. Frame number
//   is 32 bit; the check wraps 32'hFFFFFFFF -> 0. frame_done and id_err never coincide.
//  fifo_empty mid-frame: stall in state, no timeout. Outputs are held and
//   pixel_valid stays 0 until data resumes.
// CONFIGURATION
//  FRAME_SEQ_CHECK_EN defined: in DONE, seq_err=1 if a frame number has been recorded
//   since reset and the new number != previous+1; the first frame after reset is never
//   flagged. Every completed frame updates the reference, even one with an error.
//  Undefined: seq_err tied 0; frame_ok depends on tail match only; no compare logic.
// TESTING
//  1 Frame hdr,55AA0003,2592 words {i*2,i*2+1},1,tail -> 5184 pixels 0..5183 in order,
//    chip_number=3, frame_num=1, frame_done+frame_ok.
//  2 Garbage 0x12345678 x3 then a valid frame -> garbage ignored, frame decoded as in 1.
//  3 hdr followed by 0xDEAD0000 -> id_err pulse, no pixel_valid, next valid frame OK.
//  4 Valid frame with wrong tail 0x0 -> frame_done=1, frame_ok=0.
//  5 fifo_empty high for 10 cycles after word 100 -> pixels pause, index continues at 200.
//  6 FRAME_SEQ_CHECK_EN: frames numbered 1,2,4 -> seq_err only on the frame numbered 4.
//    Undefined: seq_err never asserted.
//  7 reset at pixel 1000, then a full frame -> no frame_done for the aborted frame,
//    the new frame decodes with pixel_index starting at 0.

Source files
------------

// File: rtl/data_unpacking.sv
// rtl/data_unpacking.sv - frame FIFO reader: header/ID hunt, 32->16 pixel unpack, frame status (optional FRAME_SEQ_CHECK_EN)
module data_unpacking #(
  parameter int PIXELS_PER_FRAME = 5184
) (
  input  logic        clk_200m,
  input  logic        reset,
  input  logic [31:0] header,
  input  logic [31:0] tail,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rden,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [15:0] pixel_index,
  output logic [3:0]  chip_number,
  output logic [31:0] frame_num,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        id_err,
  output logic        seq_err,
  output logic [5:0]  up_status
);

  localparam int          WORDS    = PIXELS_PER_FRAME / 2;
  localparam logic [15:0] WORDS_W  = 16'(WORDS);
  localparam logic [15:0] LAST_PIX = 16'(PIXELS_PER_FRAME - 1);
  localparam logic [15:0] ID_MARK  = 16'h55AA;

  typedef enum logic [5:0] {
    S_HUNT = 6'b000001,
    S_ID   = 6'b000010,
    S_DATA = 6'b000100,
    S_FNUM = 6'b001000,
    S_TAIL = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t      state;
  state_t      state_next;

  // One read is outstanding at most; the word shows up on fifo_dout the cycle after.
  logic        rd_pending;
  logic        word_vld;
  logic        id_ok;
  logic        consume;
  logic        seq_bad;

  logic [15:0] word_cnt;
  logic [15:0] pix_cnt;
  logic        lo_pend;
  logic [15:0] lo_half;
  logic [31:0] fnum_cand;

  assign word_vld  = rd_pending;
  assign id_ok     = (fifo_dout[31:16] == ID_MARK);
  assign up_status = state;

  // DATA stops reading once every data word of the frame has been fetched, so the
  // frame-number word is only pulled after the last lower half has gone out.
  assign consume   = (state == S_HUNT) || (state == S_ID) || (state == S_FNUM) ||
                     (state == S_TAIL) || ((state == S_DATA) && (word_cnt != WORDS_W));
  assign fifo_rden = !reset && consume && !fifo_empty && !rd_pending;

`ifdef FRAME_SEQ_CHECK_EN
  logic have_ref;

  // Remember whether any frame has completed since reset; the first one is never flagged.
  always_ff @(posedge clk_200m) begin
    if (reset) begin
      have_ref <= 1'b0;
    end else if ((state == S_TAIL) && word_vld) begin
      have_ref <= 1'b1;
    end
  end

  assign seq_bad = have_ref && (fnum_cand != (frame_num + 32'd1));
`else
  assign seq_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_200m) begin
    if (reset) begin
      state <= S_HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: every transition except DATA->FNUM and DONE->HUNT is driven by an arriving word.
  always_comb begin
    state_next = state;
    case (state)
      S_HUNT: begin
        if (word_vld && (fifo_dout == header)) begin
          state_next = S_ID;
        end
      end
      S_ID: begin
        if (word_vld) begin
          if (id_ok) begin
            state_next = S_DATA;
          end else if (fifo_dout == header) begin
            state_next = S_ID;
          end else begin
            state_next = S_HUNT;
          end
        end
      end
      S_DATA: begin
        if (!word_vld && lo_pend && (pix_cnt == LAST_PIX)) begin
          state_next = S_FNUM;
        end
      end
      S_FNUM: begin
        if (word_vld) begin
          state_next = S_TAIL;
        end
      end
      S_TAIL: begin
        if (word_vld) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_HUNT;
      end
      default: begin
        state_next = S_HUNT;
      end
    endcase
  end

  // Datapath: read tracking, pixel unpacking (upper half first) and per-frame status.
  always_ff @(posedge clk_200m) begin
    if (reset) begin
      rd_pending  <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= 16'd0;
      pixel_index <= 16'd0;
      chip_number <= 4'd0;
      frame_num   <= 32'd0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      id_err      <= 1'b0;
      seq_err     <= 1'b0;
      word_cnt    <= 16'd0;
      pix_cnt     <= 16'd0;
      lo_pend     <= 1'b0;
      lo_half     <= 16'd0;
      fnum_cand   <= 32'd0;
    end else begin
      rd_pending  <= fifo_rden;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      id_err      <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        S_ID: begin
          if (word_vld) begin
            if (id_ok) begin
              chip_number <= fifo_dout[3:0];
              pixel_index <= 16'd0;
              pix_cnt     <= 16'd0;
              word_cnt    <= 16'd0;
              lo_pend     <= 1'b0;
            end else if (fifo_dout != header) begin
              id_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (word_vld) begin
            pixel_valid <= 1'b1;
            pixel_data  <= fifo_dout[31:16];
            pixel_index <= pix_cnt;
            pix_cnt     <= pix_cnt + 16'd1;
            lo_half     <= fifo_dout[15:0];
            lo_pend     <= 1'b1;
            word_cnt    <= word_cnt + 16'd1;
          end else if (lo_pend) begin
            pixel_valid <= 1'b1;
            pixel_data  <= lo_half;
            pixel_index <= pix_cnt;
            pix_cnt     <= pix_cnt + 16'd1;
            lo_pend     <= 1'b0;
          end
        end
        S_FNUM: begin
          if (word_vld) begin
            fnum_cand <= fifo_dout;
          end
        end
        S_TAIL: begin
          // Status is registered on the tail word so it is visible during the DONE cycle.
          if (word_vld) begin
            frame_done <= 1'b1;
            frame_ok   <= (fifo_dout == tail) && !seq_bad;
            seq_err    <= seq_bad;
            frame_num  <= fnum_cand;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_unpacking.sv
// tb/tb_data_unpacking.sv - scoreboard bench for data_unpacking
module tb_data_unpacking;

  localparam int          PPF = 5184;
  localparam int          NW  = PPF / 2;
  localparam logic [31:0] HDR = 32'hFEED_C0DE;
  localparam logic [31:0] TL  = 32'hCAFE_F00D;

  logic        clk_200m = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] header = HDR;
  logic [31:0] tail = TL;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = 32'd0;
  logic        fifo_rden;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [15:0] pixel_index;
  logic [3:0]  chip_number;
  logic [31:0] frame_num;
  logic        frame_done;
  logic        frame_ok;
  logic        id_err;
  logic        seq_err;
  logic [5:0]  up_status;

  data_unpacking #(.PIXELS_PER_FRAME(PPF)) dut (
    .clk_200m(clk_200m), .reset(reset), .header(header), .tail(tail),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rden(fifo_rden),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .chip_number(chip_number), .frame_num(frame_num), .frame_done(frame_done),
    .frame_ok(frame_ok), .id_err(id_err), .seq_err(seq_err), .up_status(up_status)
  );

  always #5 clk_200m = ~clk_200m;

  typedef struct {
    logic [15:0] idx;
    logic [15:0] data;
  } pix_t;

  typedef struct {
    logic [3:0]  chip;
    logic [31:0] fnum;
    logic        ok;
    logic        seq;
  } frm_t;

  pix_t        exp_pix[$];
  frm_t        exp_frm[$];
  logic [31:0] fifo_q[$];
  int          exp_id = 0;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          pops = 0;
  int          stall_at = -1;
  int          stall_cnt = 0;
  logic        stall_mode = 1'b0;
  logic        saw_1000 = 1'b0;
  int          t199 = 0;
  int          t200 = 0;
  logic        m_have_ref = 1'b0;
  logic [31:0] m_prev = 32'd0;
  logic        took;

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] req);
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      fail_line(name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    fail_line(name, act, 32'd0);
  endtask

  // FIFO model: a word popped on a sampled fifo_rden appears on fifo_dout one cycle later.
  always @(posedge clk_200m) begin
    took = fifo_rden;
    cycle++;
    #1;
    if (stall_cnt > 0) stall_cnt--;
    if (took && fifo_q.size() > 0) begin
      fifo_dout = fifo_q.pop_front();
      pops++;
      if (pops == stall_at) stall_cnt = 10;
    end
    fifo_empty = (fifo_q.size() == 0) || (stall_cnt > 0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or a status pulse.
  always @(negedge clk_200m) begin
    pix_t e;
    frm_t f;
    if (!reset) begin
      if (pixel_valid) begin
        if (exp_pix.size() == 0) begin
          unexpected("pix_unexpected", {pixel_index, pixel_data});
        end else begin
          e = exp_pix.pop_front();
          chk("pix_index", pixel_index, e.idx);
          chk("pix_data", pixel_data, e.data);
        end
        if (stall_mode && pixel_index == 16'd199) t199 = cycle;
        if (stall_mode && pixel_index == 16'd200) t200 = cycle;
        if (pixel_index == 16'd1000) saw_1000 = 1'b1;
      end
      if (frame_done) begin
        if (exp_frm.size() == 0) begin
          unexpected("frame_done_unexpected", frame_num);
        end else begin
          f = exp_frm.pop_front();
          chk("frame_num", frame_num, f.fnum);
          chk("chip_number", chip_number, f.chip);
          chk("frame_ok", frame_ok, f.ok);
          chk("seq_err", seq_err, f.seq);
        end
      end
      if (id_err) begin
        if (exp_id == 0) unexpected("id_err_unexpected", 32'd1);
        else begin
          checks++;
          exp_id--;
        end
        if (frame_done) unexpected("id_err_with_frame_done", 32'd1);
      end
      if (seq_err && !frame_done) unexpected("seq_err_without_done", 32'd1);
    end
  end

  task automatic send_frame(input logic [3:0] chip, input logic [31:0] fnum, input logic [31:0] tw);
    frm_t f;
    pix_t p;
    logic seq;
    fifo_q.push_back(HDR);
    fifo_q.push_back({16'h55AA, 12'h000, chip});
    for (int i = 0; i < NW; i++) begin
      fifo_q.push_back({16'(2 * i), 16'(2 * i + 1)});
      p.idx = 16'(2 * i);     p.data = 16'(2 * i);     exp_pix.push_back(p);
      p.idx = 16'(2 * i + 1); p.data = 16'(2 * i + 1); exp_pix.push_back(p);
    end
    fifo_q.push_back(fnum);
    fifo_q.push_back(tw);
`ifdef FRAME_SEQ_CHECK_EN
    seq = m_have_ref && (fnum != m_prev + 32'd1);
`else
    seq = 1'b0;
`endif
    m_have_ref = 1'b1;
    m_prev = fnum;
    f.chip = chip;
    f.fnum = fnum;
    f.seq = seq;
    f.ok = (tw == TL) && !seq;
    exp_frm.push_back(f);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_pix.size() != 0 || exp_frm.size() != 0 || exp_id != 0) && n < 20000) begin
      @(posedge clk_200m);
      n++;
    end
    repeat (4) @(posedge clk_200m);
    chk(name, (n < 20000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_state();
    chk("rst_fifo_rden", fifo_rden, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_data", pixel_data, 0);
    chk("rst_pixel_index", pixel_index, 0);
    chk("rst_chip_number", chip_number, 0);
    chk("rst_frame_num", frame_num, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_id_err", id_err, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_up_status", up_status, 6'b000001);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk_200m);
    #1;
    check_reset_state();
    reset = 1'b0;

    // 1: plain frame
    send_frame(4'd3, 32'd1, TL);
    wait_idle("t1_idle");

    // 2: garbage before a frame
    repeat (3) fifo_q.push_back(32'h1234_5678);
    send_frame(4'd3, 32'd2, TL);
    wait_idle("t2_idle");

    // 3/6: bad ID word, then frame number 4 (gap after 2)
    fifo_q.push_back(HDR);
    fifo_q.push_back(32'hDEAD_0000);
    exp_id++;
    send_frame(4'd5, 32'd4, TL);
    wait_idle("t3_idle");

    // 4: wrong tail
    send_frame(4'd3, 32'd5, 32'h0);
    wait_idle("t4_idle");

    // 5: FIFO runs dry for 10 cycles after data word 100
    stall_mode = 1'b1;
    stall_at = pops + 2 + 100;
    send_frame(4'd3, 32'd6, TL);
    wait_idle("t5_idle");
    chk("stall_gap", (t200 - t199 >= 8) ? 32'd1 : 32'd0, 32'd1);
    stall_mode = 1'b0;
    stall_at = -1;

    // 7: reset mid-frame
    saw_1000 = 1'b0;
    send_frame(4'd3, 32'd7, TL);
    n = 0;
    while (!saw_1000 && n < 5000) begin
      @(posedge clk_200m);
      n++;
    end
    chk("t7_reach_1000", saw_1000, 1);
    #1;
    reset = 1'b1;
    @(posedge clk_200m);
    #1;
    fifo_q.delete();
    exp_pix.delete();
    exp_frm.delete();
    m_have_ref = 1'b0;
    check_reset_state();
    @(posedge clk_200m);
    #1;
    reset = 1'b0;
    send_frame(4'd9, 32'd100, TL);
    wait_idle("t7_idle");

    // frame-number wrap
    send_frame(4'd3, 32'hFFFF_FFFF, TL);
    send_frame(4'd3, 32'd0, TL);
    wait_idle("wrap_idle");

    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("frm_queue_empty", exp_frm.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
